// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream receive side and instruction-memory write side of the boot loader.
// master = stream source / observer, slave = the loader itself.
interface imem_loader_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             imem_we;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_wdata;
  logic             core_reset;
  logic             load_done;
  logic             load_error;
  logic [PC_W-2:0]  word_count;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
    input  core_reset, load_done, load_error, word_count
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata,
    output core_reset, load_done, load_error, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> 32-bit imem writes; core held in reset until image verified (inter-byte timeout: IMEM_LOADER_TIMEOUT_EN).
// Latency: imem_we one cycle after a word's 4th byte; load_done/core_reset change one cycle after the CSUM byte.
// Backpressure: rx_ready high in every state except DONE; one byte per cycle, memory writes never stall the stream.
module imem_loader #(
  parameter int PC_W           = 9,
  parameter int INS_W          = 32,
  parameter int MAX_WORDS      = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         WC_W = PC_W - 1;

  if (MAX_WORDS > (1 << (PC_W - 2)) || TIMEOUT_CYCLES < 1 || INS_W != 32) begin : g_param_check
    $error("imem_loader: illegal parameter combination");
  end

  logic [2:0]      state;
  logic [15:0]     len;
  logic [7:0]      csum;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_lo;
  logic [WC_W-1:0] word_count;
  logic [WC_W-1:0] wc_inc;
  logic [15:0]     len_next;
  logic            accept;
  logic            timed_out;

  assign bus.rx_ready   = (state != S_DONE);
  assign bus.word_count = word_count;
  assign accept         = bus.rx_valid && bus.rx_ready;
  assign len_next       = {bus.rx_data, len[7:0]};
  assign wc_inc         = (word_count == WC_W'(MAX_WORDS)) ? word_count : word_count + WC_W'(1);

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            in_frame;

  assign in_frame  = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA) || (state == S_CSUM);
  assign timed_out = in_frame && !accept && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (!in_frame || accept)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + TO_W'(1);
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      len            <= '0;
      csum           <= '0;
      byte_cnt       <= '0;
      word_lo        <= '0;
      word_count     <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.core_reset <= 1'b1;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      if (timed_out) begin
        state          <= S_ERROR;
        bus.load_error <= 1'b1;
      end else if (accept) begin
        unique case (state)
          S_IDLE: if (bus.rx_data == SYNC) state <= S_LEN0;
          S_LEN0: begin
            len[7:0] <= bus.rx_data;
            state    <= S_LEN1;
          end
          S_LEN1: begin
            len[15:8]  <= bus.rx_data;
            csum       <= '0;
            word_count <= '0;
            byte_cnt   <= '0;
            if (len_next > 16'(MAX_WORDS)) begin
              state          <= S_ERROR;
              bus.load_error <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            csum     <= csum ^ bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            // The 4th byte goes straight to the write port; only bytes 0..2 need holding.
            unique case (byte_cnt)
              2'd0: word_lo[7:0]   <= bus.rx_data;
              2'd1: word_lo[15:8]  <= bus.rx_data;
              2'd2: word_lo[23:16] <= bus.rx_data;
              default: begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= {word_count[PC_W-3:0], 2'b00};
                bus.imem_wdata <= {bus.rx_data, word_lo};
                word_count     <= wc_inc;
                if (16'(word_count) + 16'd1 == len) state <= S_CSUM;
              end
            endcase
          end
          S_CSUM: begin
            if (bus.rx_data == csum) begin
              state          <= S_DONE;
              bus.load_done  <= 1'b1;
              bus.core_reset <= 1'b0;
            end else begin
              state          <= S_ERROR;
              bus.load_error <= 1'b1;
            end
          end
          S_ERROR: begin
            if (bus.rx_data == SYNC) begin
              state          <= S_LEN0;
              bus.load_error <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven frame vectors, hand-written corner sequences, and randomized frames
// checked against expectations derived from how each frame was built.
module tb_imem_loader;
  localparam int PC_W      = 9;
  localparam int INS_W     = 32;
  localparam int MAX_WORDS = 128;
  localparam int TO_CYC    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.PC_W(PC_W), .INS_W(INS_W)) bus();

  imem_loader #(
    .PC_W(PC_W), .INS_W(INS_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [PC_W-1:0] addr;
    logic [31:0]     data;
  } wr_t;

  wr_t wr_q[$];
  wr_t exp_q[$];

  always @(negedge clk) if (bus.imem_we) wr_q.push_back({bus.imem_addr, bus.imem_wdata});

  typedef struct {
    int          n;
    logic [127:0] s;
    int          exp_wr;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          done;
    bit          err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'hA5;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) begin
      tests++;
      fails++;
      $display("FAIL send_byte: rx_ready stuck low for byte 0x%0h", b);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wr_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"},   bus.rx_ready,   1);
    chk({tag, "_imem_we"},    bus.imem_we,    0);
    chk({tag, "_imem_addr"},  bus.imem_addr,  0);
    chk({tag, "_imem_wdata"}, bus.imem_wdata, 0);
    chk({tag, "_core_reset"}, bus.core_reset, 1);
    chk({tag, "_load_done"},  bus.load_done,  0);
    chk({tag, "_load_error"}, bus.load_error, 0);
    chk({tag, "_word_count"}, bus.word_count, 0);
  endtask

  task automatic chk_status(input string tag, input bit done, input bit err);
    chk({tag, "_load_done"},  bus.load_done,  done);
    chk({tag, "_load_error"}, bus.load_error, err);
    chk({tag, "_core_reset"}, bus.core_reset, !done);
    chk({tag, "_rx_ready"},   bus.rx_ready,   !done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0]  fr[$];
  logic [7:0]  cs;
  logic [7:0]  b;
  logic [31:0] word;
  int          nw;
  bit          bad_cs;
  bit          exp_done;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    #1;
    chk_reset_vals("por");

    // Payload XOR of the two-word frame is 0xF0, so a trailing 0xF2 must be rejected.
    vecs[0] = '{12, {96'hA5_02_00_13_00_00_00_B3_02_52_00_F0, 32'h0}, 2, 32'h00000013, 32'h005202B3, 1, 0};
    vecs[1] = '{12, {96'hA5_02_00_13_00_00_00_B3_02_52_00_F2, 32'h0}, 2, 32'h00000013, 32'h005202B3, 0, 1};
    vecs[2] = '{6,  {48'h00_FF_A5_00_00_00, 80'h0},                  0, 32'h0,        32'h0,        1, 0};
    vecs[3] = '{8,  {64'hA5_01_00_11_22_33_44_00, 64'h0},            1, 32'h44332211, 32'h0,        0, 1};
    vecs[4] = '{8,  {64'hA5_01_00_11_22_33_44_44, 64'h0},            1, 32'h44332211, 32'h0,        1, 0};
    vecs[5] = '{3,  {24'hA5_81_00, 104'h0},                          0, 32'h0,        32'h0,        0, 1};
    vecs[6] = '{5,  {40'h12_A5_00_00_07, 88'h0},                     0, 32'h0,        32'h0,        0, 1};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].s[127-8*k -: 8], 1'b0);
      bus.rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_wr_count", i), wr_q.size(), vecs[i].exp_wr);
      if (vecs[i].exp_wr > 0 && wr_q.size() > 0) begin
        chk($sformatf("v%0d_addr0", i), wr_q[0].addr, 0);
        chk($sformatf("v%0d_data0", i), wr_q[0].data, vecs[i].d0);
      end
      if (vecs[i].exp_wr > 1 && wr_q.size() > 1) begin
        chk($sformatf("v%0d_addr1", i), wr_q[1].addr, 4);
        chk($sformatf("v%0d_data1", i), wr_q[1].data, vecs[i].d1);
      end
      chk_status($sformatf("v%0d", i), vecs[i].done, vecs[i].err);
    end

    // Write strobe timing and the CSUM byte landing in the same cycle as imem_we.
    do_reset();
    chk_reset_vals("rst");
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    chk("tm_we_before", bus.imem_we, 0);
    send_byte(8'h44, 0);
    chk("tm_we",         bus.imem_we,    1);
    chk("tm_addr",       bus.imem_addr,  0);
    chk("tm_wdata",      bus.imem_wdata, 32'h44332211);
    chk("tm_word_count", bus.word_count, 1);
    chk("tm_done_early", bus.load_done,  0);
    send_byte(8'h44, 0);
    bus.rx_valid = 1'b0;
    chk("tm_we_one_cycle", bus.imem_we, 0);
    chk_status("tm", 1, 0);

    // Error, ignored junk, then a restart that overwrites from address 0.
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    foreach (fr[k]) send_byte(fr[k], 0);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    chk_status("re_err", 0, 1);
    fr = '{8'h00, 8'h33, 8'hA5, 8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88, 8'hCC};
    foreach (fr[k]) send_byte(fr[k], 0);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_status("re_ok", 1, 0);
    chk("re_wr_count", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      chk("re_addr", wr_q[1].addr, 0);
      chk("re_data", wr_q[1].data, 32'h88776655);
    end

    // Largest legal image: bytes run 0x00..0xFF twice.
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h80, 0); send_byte(8'h00, 0);
    cs = 8'h00;
    for (int k = 0; k < 4 * MAX_WORDS; k++) begin
      b = 8'(k);
      cs ^= b;
      send_byte(b, 0);
    end
    send_byte(cs, 0);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("max_wr_count", wr_q.size(), MAX_WORDS);
    if (wr_q.size() > 0) begin
      chk("max_last_addr", wr_q[wr_q.size()-1].addr, 32'h1FC);
      chk("max_last_data", wr_q[wr_q.size()-1].data, 32'hFFFEFDFC);
    end
    chk("max_word_count", bus.word_count, MAX_WORDS);
    chk_status("max", 1, 0);

    // Asynchronous reset two payload bytes into a word.
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    foreach (fr[k]) send_byte(fr[k], 0);
    bus.rx_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_no_write", wr_q.size(), 0);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    foreach (fr[k]) send_byte(fr[k], 0);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_wr_count", wr_q.size(), 1);
    if (wr_q.size() == 1) begin
      chk("midrst_addr", wr_q[0].addr, 0);
      chk("midrst_data", wr_q[0].data, 32'h44332211);
    end
    chk_status("midrst", 1, 0);

    // Stream stalls after the length field.
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    bus.rx_valid = 1'b0;
    repeat (TO_CYC) @(negedge clk);
`ifdef IMEM_LOADER_TIMEOUT_EN
    chk_status("tmo", 0, 1);
`else
    chk_status("tmo_wait", 0, 0);
    repeat (TO_CYC) @(negedge clk);
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    foreach (fr[k]) send_byte(fr[k], 0);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("tmo_wr_count", wr_q.size(), 1);
    chk_status("tmo_resume", 1, 0);
`endif

    // Random frames: leading junk, random length (sometimes oversize), random words, occasional bad CSUM.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      fr.delete();
      exp_q.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        fr.push_back((b == 8'hA5) ? 8'h5A : b);
      end
      nw = ($urandom_range(0, 6) == 0) ? $urandom_range(MAX_WORDS + 1, 400) : $urandom_range(0, 12);
      fr.push_back(8'hA5);
      fr.push_back(8'(nw));
      fr.push_back(8'(nw >> 8));
      cs = 8'h00;
      bad_cs = 1'b0;
      if (nw <= MAX_WORDS) begin
        for (int w = 0; w < nw; w++) begin
          word = $urandom;
          for (int j = 0; j < 4; j++) begin
            fr.push_back(word[8*j +: 8]);
            cs ^= word[8*j +: 8];
          end
          exp_q.push_back({PC_W'(w * 4), word});
        end
        bad_cs = ($urandom_range(0, 3) == 0);
        fr.push_back(bad_cs ? (cs ^ 8'($urandom_range(1, 255))) : cs);
      end
      exp_done = (nw <= MAX_WORDS) && !bad_cs;
      foreach (fr[k]) send_byte(fr[k], 1'b1);
      bus.rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("rnd%0d_wr_count", it), wr_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
        chk($sformatf("rnd%0d_addr%0d", it, k), wr_q[k].addr, exp_q[k].addr);
        chk($sformatf("rnd%0d_data%0d", it, k), wr_q[k].data, exp_q[k].data);
      end
      chk_status($sformatf("rnd%0d", it), exp_done, !exp_done);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
